// File: rtl/fetch_buffer_if.sv
// Handshake bundle between fetch, the fetch buffer and decode.
// The master modport is the fetch/decode side; the slave modport is the buffer.
interface fetch_buffer_if #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic                  in_valid;
  logic [ADDR_WIDTH-1:0] in_pc;
  logic [INST_WIDTH-1:0] in_inst;
  logic                  in_ready;
  logic                  flush;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [INST_WIDTH-1:0] out_inst;
  logic                  out_ready;
  logic [PTR_WIDTH:0]    occupancy;

  modport master (
    output in_valid, in_pc, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, occupancy
  );

  modport slave (
    input  in_valid, in_pc, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, occupancy
  );
endinterface

// File: rtl/fetch_buffer.sv
// Circular {pc, inst} FIFO between IF and ID with flush and fetch back-pressure.
// Define FETCH_BUF_BYPASS_EN for a zero-latency pass-through when the buffer is empty.
module fetch_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  fetch_buffer_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH + 1)'(1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  entry_t               storage_q [DEPTH];
  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [PTR_WIDTH:0]   count_q, count_d;

  logic   empty, full, push, pop, bypass, write_en, fifo_pop;
  entry_t head_entry;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_COUNT);
`ifdef FETCH_BUF_BYPASS_EN
    bypass = empty && bus.in_valid && !bus.flush && !rst;
`else
    bypass = 1'b0;
`endif

    bus.in_ready  = !rst && !full;
    bus.out_valid = (!empty || bypass) && !bus.flush;
    bus.occupancy = count_q;

    if (!bus.out_valid)  head_entry = '0;
    else if (bypass)     head_entry = '{pc: bus.in_pc, inst: bus.in_inst};
    else                 head_entry = storage_q[head_q];
    bus.out_pc   = head_entry.pc;
    bus.out_inst = head_entry.inst;

    push = bus.in_valid && bus.in_ready;
    pop  = bus.out_valid && bus.out_ready;
    // A bypassed entry consumed in the same cycle never touches the storage.
    write_en = push && !bus.flush && !(bypass && pop);
    fifo_pop = pop && !bypass;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (write_en) tail_d = tail_q + PTR_ONE;
      if (fifo_pop) head_d = head_q + PTR_ONE;
      case ({write_en, fifo_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (write_en) storage_q[tail_q] <= '{pc: bus.in_pc, inst: bus.in_inst};
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model compared every cycle,
// plus directed literal expectations for fill/drain, streaming, full, flush, wrap and reset.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int IW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_buffer_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  ent_t          model_q[$];
  logic [AW-1:0] pushed_log[$];
  logic [AW-1:0] popped_log[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic          s_in_ready, s_out_valid;
  logic [AW-1:0] s_out_pc;
  int            s_occ;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model at the edge.
  task automatic cycle(input logic v, input logic [AW-1:0] pc, input logic f, input logic ordy);
    logic [IW-1:0] inst;
    logic          exp_rdy, exp_ov, byp, pu, po;
    ent_t          head;
    inst = $urandom;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.flush     = f;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !rst && (model_q.size() < DEPTH);
    byp     = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
    byp = (model_q.size() == 0) && v && !f && !rst;
`endif
    exp_ov = ((model_q.size() > 0) || byp) && !f;
    if (!exp_ov)                head = '{pc: '0, inst: '0};
    else if (model_q.size() > 0) head = model_q[0];
    else                        head = '{pc: pc, inst: inst};

    check("in_ready",  64'(bus.in_ready),  64'(exp_rdy));
    check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    check("out_pc",    64'(bus.out_pc),    64'(head.pc));
    check("out_inst",  64'(bus.out_inst),  64'(head.inst));
    check("occupancy", 64'(bus.occupancy), 64'(model_q.size()));

    s_in_ready  = bus.in_ready;
    s_out_valid = bus.out_valid;
    s_out_pc    = bus.out_pc;
    s_occ       = int'(bus.occupancy);

    pu = v && exp_rdy;
    po = exp_ov && ordy;
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (po) popped_log.push_back(head.pc);
      if (po && model_q.size() > 0) void'(model_q.pop_front());
      if (pu) pushed_log.push_back(pc);
      if (pu && !(byp && po)) model_q.push_back('{pc: pc, inst: inst});
    end
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (model_q.size() > 0 && guard < 20) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      guard++;
    end
    check("drain_bound", 64'(model_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int pushes, guard;
    logic seen_200;
    void'($urandom(32'h00C0FFEE));

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_occupancy", 64'(bus.occupancy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete();

    // Fill then drain.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, AW'(i * 4), 1'b0, 1'b0);
      if (i == 0) check("fill_first_ready", 64'(s_in_ready), 64'd1);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      if (i == 0) begin
        check("full_occ",   64'(s_occ),      64'd4);
        check("full_ready", 64'(s_in_ready), 64'd0);
      end
      check("drain_pc", 64'(s_out_pc), 64'(i * 4));
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("drain_empty", 64'(s_out_valid), 64'd0);

    // Streaming.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, AW'(32'h100 + i * 4), 1'b0, 1'b1);
`ifdef FETCH_BUF_BYPASS_EN
      check("stream_occ", 64'(s_occ),    64'd0);
      check("stream_pc",  64'(s_out_pc), 64'(32'h100 + i * 4));
`else
      if (i > 0) begin
        check("stream_occ", 64'(s_occ),    64'd1);
        check("stream_pc",  64'(s_out_pc), 64'(32'h100 + (i - 1) * 4));
      end
`endif
    end
    drain();

    // Full boundary: push of 0x10 against a full buffer while popping.
    for (int i = 0; i < 4; i++) cycle(1'b1, AW'(i * 4), 1'b0, 1'b0);
    cycle(1'b1, AW'(32'h10), 1'b0, 1'b1);
    check("fb_blocked", 64'(s_in_ready), 64'd0);
    check("fb_pc0",     64'(s_out_pc),   64'h0);
    cycle(1'b1, AW'(32'h10), 1'b0, 1'b1);
    check("fb_accept",  64'(s_in_ready), 64'd1);
    check("fb_pc1",     64'(s_out_pc),   64'h4);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      check("fb_order", 64'(s_out_pc), 64'(32'h8 + i * 4));
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("fb_empty", 64'(s_out_valid), 64'd0);

    // Flush with a simultaneous push.
    for (int i = 0; i < 3; i++) cycle(1'b1, AW'(32'h20 + i * 4), 1'b0, 1'b0);
    cycle(1'b1, AW'(32'h200), 1'b1, 1'b0);
    check("flush_ov", 64'(s_out_valid), 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("flush_occ", 64'(s_occ), 64'd0);
    seen_200 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      if (s_out_valid && s_out_pc == 32'h200) seen_200 = 1'b1;
    end
    check("flush_no_200", 64'(seen_200), 64'd0);

    // Wrap-around with random pops.
    popped_log.delete();
    pushed_log.delete();
    pushes = 0;
    guard  = 0;
    while ((pushes < 10 || model_q.size() > 0) && guard < 300) begin
      logic v;
      v = (pushes < 10) && ($urandom_range(0, 1) == 1);
      cycle(v, AW'(32'h300 + pushes * 4), 1'b0, 1'($urandom_range(0, 1)));
      if (v && s_in_ready) pushes++;
      guard++;
    end
    check("wrap_bound", 64'(guard < 300), 64'd1);
    check("wrap_count", 64'(popped_log.size()), 64'd10);
    for (int k = 0; k < 10 && k < popped_log.size(); k++)
      check("wrap_order", 64'(popped_log[k]), 64'(32'h300 + k * 4));

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), AW'($urandom), ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)));
    drain();

    // Asynchronous reset mid-cycle with two entries buffered.
    cycle(1'b1, AW'(32'h400), 1'b0, 1'b0);
    cycle(1'b1, AW'(32'h404), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #1;
    check("ar_pre_ov", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("ar_ov",    64'(bus.out_valid), 64'd0);
    check("ar_ready", 64'(bus.in_ready),  64'd0);
    check("ar_occ",   64'(bus.occupancy), 64'd0);
    model_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("ar_post_occ",   64'(s_occ),       64'd0);
    check("ar_post_ready", 64'(s_in_ready),  64'd1);
    check("ar_post_ov",    64'(s_out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch buffer between IF (PC + instruction ROM) and ID.
- Captures each fetched {pc, inst} pair into a small circular FIFO and presents the oldest entry to ID with a valid/ready handshake.
- Back-pressures fetch when full.
- Discards all buffered wrong-path instructions on a branch/exception flush.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- ADDR_WIDTH, 32, width of the pc field
- INST_WIDTH, 32, width of the instruction field
- PTR_WIDTH, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  fetch side: in_pc/in_inst hold a valid fetched instruction
- in_pc  in  ADDR_WIDTH  address of the fetched instruction
- in_inst  in  INST_WIDTH  instruction word from ROM
- in_ready  out  1  buffer accepts a push this cycle; low = stall PC
- flush  in  1  synchronous flush (branch taken / exception redirect)
- out_valid  out  1  head entry valid for ID
- out_pc  out  ADDR_WIDTH  head entry pc
- out_inst  out  INST_WIDTH  head entry instruction
- out_ready  in  1  ID accepts the head this cycle
- occupancy  out  PTR_WIDTH+1  current entry count, 0..DEPTH

Behaviour:
- Reset is asynchronous on rst high.
  - Clears head ptr, tail ptr and count to 0; storage contents are don't-care.
  - out_valid=0, in_ready=0 while rst is high; in_ready=1 from the first cycle after release.
- Events:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
- in_ready = !rst & (count != DEPTH).
  - No push is accepted when full, even if a pop occurs in the same cycle.
- out_valid = (count != 0) & !flush.
  - out_pc/out_inst = storage[head] when out_valid, else all zeros.
  - Outputs come from registers only; there is no combinational path from in_* to out_* (except under the optional feature).
- Push: storage[tail] <= {in_pc, in_inst}; tail <= tail+1, wrapping modulo DEPTH.
- Pop: head <= head+1, wrapping modulo DEPTH.
- Count update:
  - push & !pop: +1
  - pop & !push: -1
  - push & pop: unchanged
- Latency: a pushed entry is visible at out_* on the next rising edge (1 cycle) when the buffer was empty.
- Ordering is strict FIFO; entries are never reordered or duplicated.
- Flush has highest priority and takes effect at the rising edge.
  - Sets head=tail=0 and count=0.
  - Any push in the same cycle is discarded.
  - out_valid is forced 0 in the flush cycle, so no pop occurs.
  - in_ready is unaffected by flush; the fetch side treats its own flush-cycle output as dropped.
- Boundaries:
  - Empty and pop attempted: no-op (out_valid=0).
  - Full: in_ready=0 until a pop occurs; the push is then accepted in the next cycle.
  - Pointer wrap: after DEPTH pushes the tail returns to 0; full/empty are distinguished by count, not by pointer equality.
  - Reset mid-stream: all entries lost; no spurious out_valid after release.

Optional Feature:
- Macro: FETCH_BUF_BYPASS_EN.
- Defined:
  - When count==0, !flush and in_valid, out_valid=1 and out_pc/out_inst = in_pc/in_inst combinationally (zero-latency pass-through).
  - If out_ready is also high, the entry is consumed directly and not written (count stays 0).
  - If out_ready is low, the entry is written normally.
- Undefined: no bypass; minimum latency is 1 cycle as above.

Test Plan:
- Fill/drain: out_ready=0; push pc 0x00,0x04,0x08,0x0C.
  - Required: occupancy=4, in_ready=0.
  - Then out_ready=1: out_pc sequence 0x00,0x04,0x08,0x0C on consecutive cycles, then out_valid=0.
- Streaming: in_valid=1 and out_ready=1 continuously, pc 0x100 stepping +4.
  - Required: occupancy stays 1, out_pc lags in_pc by exactly 1 cycle.
  - With FETCH_BUF_BYPASS_EN: occupancy 0 and out_pc equals in_pc in the same cycle.
- Full boundary: fill to 4, then assert out_ready and in_valid (pc 0x10) together.
  - Required: 0x10 is not accepted that cycle; it is accepted the next cycle; order 0x00..0x0C,0x10 is preserved.
- Flush: 3 entries buffered, flush=1 with in_valid=1 (pc 0x200).
  - Required: out_valid=0 in that cycle, occupancy=0 next cycle, 0x200 never appears at out_pc.
- Wrap-around: 10 pushes interleaved with pops (random out_ready, seed fixed).
  - Required: out_pc sequence equals the push sequence exactly; no loss or duplication across pointer wrap.
- Async reset: assert rst mid-cycle with 2 entries buffered.
  - Required: out_valid and in_ready fall immediately without waiting for an edge; after release occupancy=0 and in_ready=1.
